// File: rtl/bp_cce_alu_arbiter.sv
// Round-robin arbiter sharing one CCE ALU among several requesters; the winner's
// result is held in a one-entry output register tagged with its requester ID.

package bp_cce_pkg;

  typedef enum logic [3:0] {
    e_alu_add = 4'd0,
    e_alu_sub = 4'd1,
    e_alu_lsh = 4'd2,
    e_alu_rsh = 4'd3,
    e_alu_and = 4'd4,
    e_alu_or  = 4'd5,
    e_alu_xor = 4'd6,
    e_alu_neg = 4'd7,
    e_alu_inc = 4'd8,
    e_alu_dec = 4'd9
  } bp_cce_inst_minor_alu_op_e;

endpackage

module bp_cce_alu
  import bp_cce_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0]         opd_a_i,
  input  logic [width_p-1:0]         opd_b_i,
  input  bp_cce_inst_minor_alu_op_e  alu_op_i,
  output logic [width_p-1:0]         res_o
);

  localparam logic [width_p-1:0] width_lp = width_p'(width_p);

  logic shift_oob_s;
  assign shift_oob_s = (opd_b_i >= width_lp);

  // Combinational ALU; shifts use the whole B operand and saturate to zero.
  always_comb begin
    res_o = '0;
    case (alu_op_i)
      e_alu_add: res_o = opd_a_i + opd_b_i;
      e_alu_sub: res_o = opd_a_i - opd_b_i;
      e_alu_lsh: begin
        if (shift_oob_s) res_o = '0;
        else             res_o = opd_a_i << opd_b_i;
      end
      e_alu_rsh: begin
        if (shift_oob_s) res_o = '0;
        else             res_o = opd_a_i >> opd_b_i;
      end
      e_alu_and: res_o = opd_a_i & opd_b_i;
      e_alu_or:  res_o = opd_a_i | opd_b_i;
      e_alu_xor: res_o = opd_a_i ^ opd_b_i;
      e_alu_neg: res_o = ~opd_a_i;
      e_alu_inc: res_o = opd_a_i + width_p'(1);
      e_alu_dec: res_o = opd_a_i - width_p'(1);
      default:   res_o = '0;
    endcase
  end

endmodule

module bp_cce_alu_arbiter_checker #(
  parameter int num_req_p = 2
) (
  input logic                 clk_i,
  input logic                 reset_i,
  input logic                 v_i,
  input logic                 yumi_i,
  input logic [num_req_p-1:0] req_yumi_i
);

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_i);
  grant_onehot0:        assert property (@(posedge clk_i) $onehot0(req_yumi_i));
  no_grant_on_stall:    assert property (@(posedge clk_i) (v_i && !yumi_i) |-> (req_yumi_i == '0));
  no_grant_in_reset:    assert property (@(posedge clk_i) reset_i |-> (req_yumi_i == '0));

endmodule

module bp_cce_alu_arbiter
  import bp_cce_pkg::*;
#(
  parameter  int width_p       = 8,
  parameter  int num_req_p     = 2,
  localparam int lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p-1:0][width_p-1:0]      req_opd_a_i,
  input  logic [num_req_p-1:0][width_p-1:0]      req_opd_b_i,
  input  bp_cce_inst_minor_alu_op_e [num_req_p-1:0] req_alu_op_i,
  output logic [num_req_p-1:0]                   req_yumi_o,
  output logic                                   v_o,
  output logic [width_p-1:0]                     res_o,
  output logic [lg_num_req_lp-1:0]               res_id_o,
  input  logic                                   yumi_i
);

  localparam logic [lg_num_req_lp:0]   num_req_lp  = (lg_num_req_lp+1)'(num_req_p);
  localparam logic [lg_num_req_lp-1:0] last_rst_lp = lg_num_req_lp'(num_req_p - 1);

  logic [lg_num_req_lp-1:0] last_q, last_d;
  logic                     v_q, v_d;
  logic [width_p-1:0]       res_q, res_d;
  logic [lg_num_req_lp-1:0] id_q, id_d;

  logic [lg_num_req_lp-1:0] win_s;
  logic [lg_num_req_lp:0]   cand_s;
  logic                     found_s;
  logic                     can_issue_s;
  logic                     grant_s;
  logic [width_p-1:0]       alu_res_s;

  // Round-robin search starting just after the last winner, wrapping modulo num_req_p.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      cand_s = {1'b0, last_q} + (lg_num_req_lp+1)'(i);
      if (cand_s >= num_req_lp) cand_s = cand_s - num_req_lp;
      else                      cand_s = cand_s;
      if (!found_s && req_v_i[cand_s[lg_num_req_lp-1:0]]) begin
        win_s   = cand_s[lg_num_req_lp-1:0];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign can_issue_s = ~v_q | yumi_i;
  assign grant_s     = can_issue_s & found_s & ~reset_i;

  // One-hot grant to the winner; the request is consumed this cycle.
  always_comb begin
    req_yumi_o = '0;
    if (grant_s) req_yumi_o[win_s] = 1'b1;
    else         req_yumi_o = '0;
  end

  bp_cce_alu #(
    .width_p (width_p)
  ) alu (
    .opd_a_i  (req_opd_a_i[win_s]),
    .opd_b_i  (req_opd_b_i[win_s]),
    .alu_op_i (req_alu_op_i[win_s]),
    .res_o    (alu_res_s)
  );

  // Output register: a grant loads a fresh result even while the old one drains.
  always_comb begin
    v_d    = v_q;
    res_d  = res_q;
    id_d   = id_q;
    last_d = last_q;
    if (grant_s) begin
      v_d    = 1'b1;
      res_d  = alu_res_s;
      id_d   = win_s;
      last_d = win_s;
    end else if (yumi_i) begin
      v_d = 1'b0;
    end else begin
      v_d = v_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      res_q  <= '0;
      id_q   <= '0;
      last_q <= last_rst_lp;
    end else begin
      v_q    <= v_d;
      res_q  <= res_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  assign v_o      = v_q;
  assign res_o    = res_q;
  assign res_id_o = id_q;

  bp_cce_alu_arbiter_checker #(
    .num_req_p (num_req_p)
  ) checker_inst (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (v_q),
    .yumi_i     (yumi_i),
    .req_yumi_i (req_yumi_o)
  );

endmodule

// File: tb/tb_bp_cce_alu_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared every
// cycle against a transaction-level model of the arbiter and ALU.

module tb_bp_cce_alu_arbiter;
  import bp_cce_pkg::*;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int LG = $clog2(N);

  logic                               clk = 1'b0;
  logic                               reset_i;
  logic [N-1:0]                       req_v;
  logic [N-1:0][W-1:0]                opa, opb;
  bp_cce_inst_minor_alu_op_e [N-1:0]  op;
  logic [N-1:0]                       req_yumi;
  logic                               v;
  logic [W-1:0]                       res;
  logic [LG-1:0]                      res_id;
  logic                               cons_ready;
  logic                               yumi;

  int n_checks = 0;
  int n_err    = 0;

  int m_last  = N - 1;
  bit m_v     = 1'b0;
  int m_res   = 0;
  int m_id    = 0;
  bit m_known = 1'b0;

  always #5 clk = ~clk;

  // Consumer only ever accepts a valid result.
  assign yumi = cons_ready & v;

  bp_cce_alu_arbiter #(
    .width_p   (W),
    .num_req_p (N)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_v_i      (req_v),
    .req_opd_a_i  (opa),
    .req_opd_b_i  (opb),
    .req_alu_op_i (op),
    .req_yumi_o   (req_yumi),
    .v_o          (v),
    .res_o        (res),
    .res_id_o     (res_id),
    .yumi_i       (yumi)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_alu(input int o, input int a, input int b);
    int r;
    case (o)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = (b >= W) ? 0 : (a << b);
      3:       r = (b >= W) ? 0 : (a >> b);
      4:       r = a & b;
      5:       r = a | b;
      6:       r = a ^ b;
      7:       r = ~a;
      8:       r = a + 1;
      9:       r = a - 1;
      default: r = 0;
    endcase
    return r & ((1 << W) - 1);
  endfunction

  // Per-cycle comparison against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    int  w;
    int  idx;
    int  exp_y;
    bit  grant;
    w     = 0;
    exp_y = 0;
    grant = 1'b0;
    if (!reset_i && (!m_v || yumi) && (req_v != '0)) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!grant && req_v[idx]) begin
          w     = idx;
          grant = 1'b1;
        end
      end
      exp_y = 1 << w;
    end
    chk("grant", int'(req_yumi), exp_y);
    if (m_known) begin
      chk("v_o", int'(v), int'(m_v));
      chk("res_o", int'(res), m_res);
      chk("res_id_o", int'(res_id), m_id);
    end
    if (reset_i) begin
      m_v     = 1'b0;
      m_res   = 0;
      m_id    = 0;
      m_last  = N - 1;
      m_known = 1'b1;
    end else if (grant) begin
      m_res  = ref_alu(int'(op[w]), int'(opa[w]), int'(opb[w]));
      m_id   = w;
      m_v    = 1'b1;
      m_last = w;
    end else if (yumi) begin
      m_v = 1'b0;
    end
  end

  task automatic set_req(input int k, input int a, input int b, input int o);
    opa[k]   = W'(a);
    opb[k]   = W'(b);
    op[k]    = bp_cce_inst_minor_alu_op_e'(4'(o));
    req_v[k] = 1'b1;
  endtask

  // Advance one cycle; requesters drop whatever was granted at that edge.
  task automatic tick();
    logic [N-1:0] g;
    #1;
    g = req_yumi;
    @(posedge clk);
    #1;
    req_v = req_v & ~g;
  endtask

  initial begin
    reset_i    = 1'b1;
    cons_ready = 1'b0;
    req_v      = '0;
    opa        = '0;
    opb        = '0;
    op         = '{default: e_alu_add};
    set_req(0, 8'h01, 8'h02, 0);
    set_req(1, 8'h0F, 8'h01, 0);
    #1;

    repeat (3) begin
      tick();
      chk("rst_yumi", int'(req_yumi), 0);
      chk("rst_v", int'(v), 0);
      chk("rst_res", int'(res), 0);
    end

    reset_i = 1'b0;
    #1;
    chk("first_grant", int'(req_yumi), 1);
    tick();
    chk("first_v", int'(v), 1);
    chk("first_res", int'(res), 8'h03);
    chk("first_id", int'(res_id), 0);

    repeat (5) begin
      chk("stall_yumi", int'(req_yumi), 0);
      chk("stall_res", int'(res), 8'h03);
      tick();
    end

    cons_ready = 1'b1;
    #1;
    chk("drain_grant", int'(req_yumi), 2);
    tick();
    chk("single_v", int'(v), 1);
    chk("single_res", int'(res), 8'h10);
    chk("single_id", int'(res_id), 1);

    tick();
    chk("idle_drain_v", int'(v), 0);

    for (int i = 0; i < 4; i++) begin
      set_req(0, 8'h00, 8'h01, 1);
      set_req(1, 8'h01, 9, 2);
      #1;
      chk("rr_grant", int'(req_yumi), (i % 2 == 0) ? 1 : 2);
      tick();
      chk("rr_v", int'(v), 1);
      chk("rr_res", int'(res), (i % 2 == 0) ? 8'hFF : 8'h00);
      chk("rr_id", int'(res_id), i % 2);
    end

    cons_ready = 1'b0;
    set_req(1, 8'h22, 8'h11, 0);
    reset_i = 1'b1;
    tick();
    chk("rst_mid_v", int'(v), 0);
    reset_i = 1'b0;
    #1;
    chk("post_rst_grant", int'(req_yumi), 1);
    tick();

    repeat (3000) begin
      for (int k = 0; k < N; k++) begin
        if (!req_v[k] && ($urandom_range(0, 1) == 1)) begin
          set_req(k, int'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10)),
                  int'($urandom_range(0, 15)));
        end
      end
      cons_ready = ($urandom_range(0, 3) != 0);
      reset_i    = ($urandom_range(0, 199) == 0);
      tick();
    end

    reset_i    = 1'b0;
    cons_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
